// File: rtl/video_pkg.sv
// Shared types for the video capture path: pixel and stream-beat payloads and
// the capture FSM state encoding.
package video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    WAIT_FIRST,
    ACTIVE,
    DROP
  } cap_state_t;

  typedef struct packed {
    logic   sop;
    logic   eop;
    pixel_t pix;
  } stream_beat_t;

endpackage

// File: rtl/video_stream_fifo.sv
// Show-ahead FIFO of stream beats with a registered output stage; the output
// register counts toward capacity, so DEPTH beats are held in total.
module video_stream_fifo
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en_i,
  input  stream_beat_t wr_beat_i,
  input  logic         rd_ready_i,
  output logic         rd_valid_o,
  output stream_beat_t rd_beat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  stream_beat_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  stream_beat_t  out_beat_q, out_beat_d;
  logic          load;
  logic          mem_pop;
  logic [CW-1:0] total;

  // The output register refills whenever it is empty or being consumed.
  always_comb begin
    load        = !out_valid_q || rd_ready_i;
    mem_pop     = load && (count_q != '0);
    total       = count_q + CW'(out_valid_q);
    wr_ptr_d    = wr_ptr_q + AW'(wr_en_i);
    rd_ptr_d    = rd_ptr_q + AW'(mem_pop);
    count_d     = count_q + CW'(wr_en_i) - CW'(mem_pop);
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    if (load) out_valid_d = (count_q != '0);
    if (mem_pop) out_beat_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_beat_i;
  end

  assign rd_valid_o = out_valid_q;
  assign rd_beat_o  = out_beat_q;
  assign full_o     = (total == CW'(DEPTH));
  assign empty_o    = (total == '0);

endmodule

// File: rtl/video_stream_capture.sv
// Parallel RGB + HD/VD/DEN capture into an Avalon-ST packet stream, one packet
// per frame, with overflow and frame-shape error reporting.
module video_stream_capture
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] rgb_in,
  input  logic        hd,
  input  logic        vd,
  input  logic        den,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_empty,
  output logic        overflow,
  output logic        frame_err
);

  localparam int unsigned CW         = $clog2(H_ACTIVE + 1);
  localparam int unsigned RW         = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam bit          SINGLE_PIX = (H_ACTIVE == 1) && (V_ACTIVE == 1);

  pixel_t        rgb_q;
  logic          hd_act_q, vd_act_q, den_q;
  logic          hd_prev_q, vd_prev_q, den_prev_q;
  cap_state_t    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          bad_line_q, bad_line_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  logic          vd_edge, hd_edge, den_fall, last_pix, can_write;
  logic          fifo_wr, fifo_full, fifo_empty, fifo_valid;
  stream_beat_t  fifo_wbeat, fifo_rbeat;

  // Input stage: syncs are stored as "asserted" regardless of polarity.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_q      <= '0;
      hd_act_q   <= 1'b0;
      vd_act_q   <= 1'b0;
      den_q      <= 1'b0;
      hd_prev_q  <= 1'b0;
      vd_prev_q  <= 1'b0;
      den_prev_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_in;
      hd_act_q   <= SYNC_ACTIVE_LOW ? !hd : hd;
      vd_act_q   <= SYNC_ACTIVE_LOW ? !vd : vd;
      den_q      <= den;
      hd_prev_q  <= hd_act_q;
      vd_prev_q  <= vd_act_q;
      den_prev_q <= den_q;
    end
  end

  assign vd_edge   = vd_act_q && !vd_prev_q;
  assign hd_edge   = hd_act_q && !hd_prev_q;
  assign den_fall  = den_prev_q && !den_q;
  assign last_pix  = (row_q == RW'(V_ACTIVE - 1)) && (col_q == CW'(H_ACTIVE - 1));
  assign can_write = !fifo_full || (fifo_valid && out_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_VSYNC;
      col_q       <= '0;
      row_q       <= '0;
      bad_line_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bad_line_q  <= bad_line_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Counters only live in ACTIVE; every other state holds them cleared.
  always_comb begin
    state_d        = state_q;
    col_d          = '0;
    row_d          = '0;
    bad_line_d     = 1'b0;
    overflow_d     = overflow_q;
    frame_err_d    = 1'b0;
    fifo_wr        = 1'b0;
    fifo_wbeat     = '0;
    fifo_wbeat.pix = rgb_q;
    unique case (state_q)
      WAIT_VSYNC: begin
        if (vd_edge) state_d = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (den_q) begin
          if (can_write) begin
            fifo_wr        = 1'b1;
            fifo_wbeat.sop = 1'b1;
            fifo_wbeat.eop = SINGLE_PIX;
            col_d          = CW'(1);
            state_d        = SINGLE_PIX ? WAIT_VSYNC : ACTIVE;
          end else begin
            overflow_d = 1'b1;
            state_d    = DROP;
          end
        end
      end
      ACTIVE: begin
        col_d      = col_q;
        row_d      = row_q;
        bad_line_d = bad_line_q;
        if (vd_edge) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_FIRST;
        end else if (den_q) begin
          col_d = col_q + CW'(1);
          if (can_write) begin
            fifo_wr = 1'b1;
            // A frame that already had a bad line closes without eop.
            fifo_wbeat.eop = last_pix && !bad_line_q;
            if (last_pix) state_d = WAIT_VSYNC;
          end else begin
            overflow_d = 1'b1;
            state_d    = DROP;
          end
        end else if (den_fall) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (col_q != CW'(H_ACTIVE)) begin
            frame_err_d = 1'b1;
            bad_line_d  = 1'b1;
          end
        end else if (hd_edge) begin
          col_d = '0;
        end
      end
      DROP: begin
        if (vd_edge) state_d = WAIT_FIRST;
      end
      default: state_d = WAIT_VSYNC;
    endcase
  end

  video_stream_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (fifo_wr),
    .wr_beat_i (fifo_wbeat),
    .rd_ready_i(out_ready),
    .rd_valid_o(fifo_valid),
    .rd_beat_o (fifo_rbeat),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid = fifo_valid && !fifo_empty;
  assign out_data  = fifo_rbeat.pix;
  assign out_sop   = fifo_rbeat.sop;
  assign out_eop   = fifo_rbeat.eop;
  assign out_empty = 1'b0;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
